// File: rtl/block_fill_if.sv
// Bundle of the refill engine's request, memory-port and block-store signals.
// master : the refill engine (drives mem_req/mem_addr and the fill strobes)
// slave  : the surrounding control table, block store and memory model
interface block_fill_if #(
  parameter int EXTERNAL_ADDR_SIZE = 16,
  parameter int WORD_SIZE          = 8,
  parameter int WORDS_PER_BLOCK    = 4
);
  localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK);

  logic                          miss_req;
  logic [EXTERNAL_ADDR_SIZE-1:0] miss_addr;
  logic                          flush;
  logic                          mem_req;
  logic [EXTERNAL_ADDR_SIZE-1:0] mem_addr;
  logic                          mem_ack;
  logic [WORD_SIZE-1:0]          mem_rdata;
  logic                          fill_we;
  logic [OFF_BITS-1:0]           fill_idx;
  logic [WORD_SIZE-1:0]          fill_data;
  logic                          block_ready;
  logic                          busy;
  logic                          fill_error;

  modport master (
    input  miss_req, miss_addr, flush, mem_ack, mem_rdata,
    output mem_req, mem_addr, fill_we, fill_idx, fill_data,
           block_ready, busy, fill_error
  );

  modport slave (
    output miss_req, miss_addr, flush, mem_ack, mem_rdata,
    input  mem_req, mem_addr, fill_we, fill_idx, fill_data,
           block_ready, busy, fill_error
  );
endinterface

// File: rtl/block_fill_engine.sv
// Cache block refill controller: on a miss, reads one whole block from
// external memory word by word over a req/ack handshake and writes each word
// into the block store, then pulses block_ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    block_fill_if.master: miss_req/miss_addr/flush in, mem_req/mem_addr
//          out with mem_ack/mem_rdata in, fill_we/fill_idx/fill_data out,
//          block_ready/busy/fill_error status out
//
// state | meaning
// IDLE  | waiting for miss_req
// FETCH | mem_req high, waiting for mem_ack (bounded by TIMEOUT cycles)
// WRITE | one-cycle fill_we of the word just returned
// DONE  | one-cycle block_ready pulse
//
// Every output is a register loaded with the value belonging to the state
// being entered, so outputs line up with the state and never follow inputs
// combinationally.
module block_fill_engine #(
  parameter int EXTERNAL_ADDR_SIZE = 16,
  parameter int WORD_SIZE          = 8,
  parameter int WORDS_PER_BLOCK    = 4,
  parameter int TIMEOUT            = 15
) (
  input logic          clk,
  input logic          rst_n,
  block_fill_if.master bus
);
  localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_BITS = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EXTERNAL_ADDR_SIZE-1:0] OFF_MASK  = EXTERNAL_ADDR_SIZE'(WORDS_PER_BLOCK - 1);
  localparam logic [OFF_BITS-1:0]           IDX_LAST  = OFF_BITS'(WORDS_PER_BLOCK - 1);
  // The counter holds FETCH cycles already spent, so the TIMEOUT-th cycle
  // without an ack is the one that sees TIMEOUT-1.
  localparam logic [CNT_BITS-1:0]           TMO_LAST  = CNT_BITS'(TIMEOUT - 1);
  localparam logic [WORD_SIZE-1:0]          DATA_ZERO = '0;

  logic [1:0]                    state;
  logic [EXTERNAL_ADDR_SIZE-1:0] base;
  logic [OFF_BITS-1:0]           idx;
  logic [CNT_BITS-1:0]           tmo_cnt;

  logic [EXTERNAL_ADDR_SIZE-1:0] miss_base;
  logic [OFF_BITS-1:0]           idx_next;

  assign miss_base = bus.miss_addr & ~OFF_MASK;
  assign idx_next  = idx + OFF_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base            <= '0;
      idx             <= '0;
      tmo_cnt         <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.fill_we     <= 1'b0;
      bus.fill_idx    <= '0;
      bus.fill_data   <= DATA_ZERO;
      bus.block_ready <= 1'b0;
      bus.busy        <= 1'b0;
      bus.fill_error  <= 1'b0;
    end else begin
      bus.fill_we     <= 1'b0;
      bus.block_ready <= 1'b0;
      bus.fill_error  <= 1'b0;

      case (state)
        IDLE: begin
          // flush is meaningless here, so a coincident miss_req wins.
          if (bus.miss_req) begin
            base         <= miss_base;
            idx          <= '0;
            tmo_cnt      <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= miss_base;
            bus.busy     <= 1'b1;
            state        <= FETCH;
          end
        end

        FETCH: begin
          // Priority: flush, then ack, then timeout.
          if (bus.flush) begin
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else if (bus.mem_ack) begin
            bus.fill_data <= bus.mem_rdata;
            bus.fill_idx  <= idx;
            bus.fill_we   <= 1'b1;
            bus.mem_req   <= 1'b0;
            state         <= WRITE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.fill_error <= 1'b1;
            bus.mem_req    <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_BITS'(1);
          end
        end

        WRITE: begin
          if (bus.flush) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (idx == IDX_LAST) begin
            bus.block_ready <= 1'b1;
            state           <= DONE;
          end else begin
            idx          <= idx_next;
            tmo_cnt      <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= base | EXTERNAL_ADDR_SIZE'(idx_next);
            state        <= FETCH;
          end
        end

        default: begin
          // DONE always returns to IDLE, flush or not.
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_fill_engine.sv
// Bench for block_fill_engine: a table of refill vectors, randomized refills
// scored against a cycle-count/transaction model, and hand-written sequences
// for flush, asynchronous reset and back-to-back requests.
// Cycle n of a refill is the clock period between edge n-1 and edge n, where
// edge 0 is the edge that accepts miss_req.
module tb_block_fill_engine;
  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int WPB     = 4;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;

  block_fill_if #(.EXTERNAL_ADDR_SIZE(AW), .WORD_SIZE(DW), .WORDS_PER_BLOCK(WPB)) bus ();

  block_fill_engine #(
    .EXTERNAL_ADDR_SIZE(AW), .WORD_SIZE(DW), .WORDS_PER_BLOCK(WPB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] word_data [WPB];
  int            waits     [WPB];

  typedef struct {
    logic [AW-1:0] addr;
    int            wait_cyc;
    int            exp_cycle;
    int            exp_writes;
    bit            exp_tmo;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation: word i costs waits[i]+2 cycles (fetch
  // cycles plus one write); a word left unanswered for TIMEOUT fetch cycles
  // ends the refill with fill_error in the following cycle.
  task automatic model(output int exp_cycle, output int exp_writes, output bit exp_tmo);
    int t;
    t          = 1;
    exp_tmo    = 1'b0;
    exp_writes = WPB;
    exp_cycle  = 0;
    for (int i = 0; i < WPB; i++) begin
      if (!exp_tmo) begin
        if (waits[i] >= TIMEOUT) begin
          exp_cycle  = t + TIMEOUT;
          exp_writes = i;
          exp_tmo    = 1'b1;
        end else begin
          t += waits[i] + 2;
        end
      end
    end
    if (!exp_tmo) exp_cycle = t;
  endtask

  // Issue one miss and act as the memory until busy drops. The memory acks
  // word k after waits[k] cycles of mem_req and returns word_data[k].
  task automatic run_refill(input logic [AW-1:0] addr, input int exp_cycle,
                            input int exp_writes, input bit exp_tmo,
                            input bit spur, input string tag);
    logic [AW-1:0] exp_base;
    int  c, waited, nwrites, n_ready, n_err, ready_cyc, err_cyc;
    bit  done;
    exp_base = addr & ~AW'(WPB - 1);
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    bus.mem_ack   = 1'b0;
    step();
    bus.miss_req = 1'b0;
    c = 1; waited = 0; nwrites = 0; n_ready = 0; n_err = 0;
    ready_cyc = 0; err_cyc = 0; done = 1'b0;
    while (!done && c <= 200) begin
      if (bus.fill_we) begin
        if (nwrites < WPB) begin
          check({tag, ".fill_idx"}, 32'(bus.fill_idx), 32'(nwrites));
          check({tag, ".fill_data"}, 32'(bus.fill_data), 32'(word_data[nwrites]));
        end
        nwrites++;
      end
      if (bus.block_ready) begin
        n_ready++;
        if (ready_cyc == 0) ready_cyc = c;
      end
      if (bus.fill_error) begin
        n_err++;
        if (err_cyc == 0) err_cyc = c;
      end
      if (bus.mem_req && nwrites < WPB) begin
        check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(exp_base + AW'(nwrites)));
        if (waited == waits[nwrites]) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = word_data[nwrites];
          waited        = 0;
        end else begin
          bus.mem_ack = 1'b0;
          waited++;
        end
      end else begin
        bus.mem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = DW'($urandom);
      end
      if (!bus.busy) begin
        done = 1'b1;
      end else begin
        step();
        c++;
      end
    end
    bus.mem_ack = 1'b0;
    check({tag, ".finished_in_bound"}, 32'(done), 32'd1);
    check({tag, ".writes"}, 32'(nwrites), 32'(exp_writes));
    if (exp_tmo) begin
      check({tag, ".error_cycle"}, 32'(err_cyc), 32'(exp_cycle));
      check({tag, ".error_pulses"}, 32'(n_err), 32'd1);
      check({tag, ".ready_pulses"}, 32'(n_ready), 32'd0);
      check({tag, ".idle_cycle"}, 32'(c), 32'(exp_cycle));
    end else begin
      check({tag, ".ready_cycle"}, 32'(ready_cyc), 32'(exp_cycle));
      check({tag, ".ready_pulses"}, 32'(n_ready), 32'd1);
      check({tag, ".error_pulses"}, 32'(n_err), 32'd0);
      check({tag, ".idle_cycle"}, 32'(c), 32'(exp_cycle + 1));
    end
    check({tag, ".mem_req_idle"}, 32'(bus.mem_req), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"},     32'(bus.mem_req),     32'd0);
    check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'd0);
    check({tag, ".fill_we"},     32'(bus.fill_we),     32'd0);
    check({tag, ".fill_idx"},    32'(bus.fill_idx),    32'd0);
    check({tag, ".fill_data"},   32'(bus.fill_data),   32'd0);
    check({tag, ".block_ready"}, 32'(bus.block_ready), 32'd0);
    check({tag, ".busy"},        32'(bus.busy),        32'd0);
    check({tag, ".fill_error"},  32'(bus.fill_error),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e_cyc, e_wr, c, nw, nr, ready1, ready2;
    bit  e_tmo, flushed;
    logic [AW-1:0] a;

    vecs[0] = '{addr: 16'h1237, wait_cyc: 0,  exp_cycle: 9,  exp_writes: 4, exp_tmo: 1'b0};
    vecs[1] = '{addr: 16'h1237, wait_cyc: 3,  exp_cycle: 21, exp_writes: 4, exp_tmo: 1'b0};
    vecs[2] = '{addr: 16'h0000, wait_cyc: 1,  exp_cycle: 13, exp_writes: 4, exp_tmo: 1'b0};
    vecs[3] = '{addr: 16'hFFFF, wait_cyc: 14, exp_cycle: 65, exp_writes: 4, exp_tmo: 1'b0};
    vecs[4] = '{addr: 16'h8ABC, wait_cyc: 15, exp_cycle: 16, exp_writes: 0, exp_tmo: 1'b1};
    vecs[5] = '{addr: 16'h4001, wait_cyc: 2,  exp_cycle: 17, exp_writes: 4, exp_tmo: 1'b0};

    rst_n         = 1'b0;
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Table-driven refills
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < WPB; i++) begin
        waits[i]     = vecs[v].wait_cyc;
        word_data[i] = (v == 0) ? DW'(8'hAA + 8'h11 * i) : DW'($urandom);
      end
      run_refill(vecs[v].addr, vecs[v].exp_cycle, vecs[v].exp_writes,
                 vecs[v].exp_tmo, 1'b0, $sformatf("vec%0d", v));
      step();
    end

    // Randomized refills against the model, with stray acks outside FETCH
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < WPB; i++) begin
        waits[i]     = $urandom_range(0, 4);
        word_data[i] = DW'($urandom);
      end
      if ($urandom_range(0, 5) == 0)
        waits[$urandom_range(0, WPB - 1)] = TIMEOUT + $urandom_range(0, 2);
      model(e_cyc, e_wr, e_tmo);
      a = AW'($urandom);
      run_refill(a, e_cyc, e_wr, e_tmo, 1'b1, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) step();
    end

    // Flush in the cycle word 2 is acked
    for (int i = 0; i < WPB; i++) begin
      waits[i] = 0;
      word_data[i] = DW'($urandom);
    end
    step();
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h2468;
    step();
    bus.miss_req = 1'b0;
    nw = 0; nr = 0; flushed = 1'b0;
    for (c = 1; c <= 20 && !flushed; c++) begin
      if (bus.fill_we) nw++;
      if (bus.block_ready) nr++;
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = DW'($urandom);
      bus.flush     = bus.mem_req && (nw == 2);
      flushed       = bus.flush;
      step();
    end
    bus.flush   = 1'b0;
    bus.mem_ack = 1'b0;
    check("flush.seen", 32'(flushed), 32'd1);
    check("flush.mem_req",     32'(bus.mem_req),     32'd0);
    check("flush.fill_we",     32'(bus.fill_we),     32'd0);
    check("flush.block_ready", 32'(bus.block_ready), 32'd0);
    check("flush.busy",        32'(bus.busy),        32'd0);
    step();
    check("flush.quiet_we",    32'(bus.fill_we),     32'd0);
    check("flush.quiet_ready", 32'(bus.block_ready), 32'd0);
    check("flush.writes", 32'(nw), 32'd2);
    check("flush.readies", 32'(nr), 32'd0);
    run_refill(16'h2468, 9, 4, 1'b0, 1'b0, "after_flush");
    step();

    // Asynchronous reset in the middle of FETCH
    for (int i = 0; i < WPB; i++) waits[i] = 100;
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h5A5A;
    step();
    bus.miss_req = 1'b0;
    step();
    step();
    check("areset.pre_mem_req", 32'(bus.mem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("areset");
    #2;
    rst_n = 1'b1;
    step();
    check("areset.stays_idle", 32'(bus.busy), 32'd0);
    step();

    // miss_req held high: second refill uses the address seen in its IDLE cycle
    for (int i = 0; i < WPB; i++) begin
      waits[i] = 0;
      word_data[i] = DW'($urandom);
    end
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h0F0D;
    step();
    nw = 0; ready1 = 0; ready2 = 0;
    for (c = 1; c <= 22; c++) begin
      if (c == 3) bus.miss_addr = 16'hABCD;
      if (bus.fill_we) nw++;
      if (bus.block_ready) begin
        if (ready1 == 0) ready1 = c;
        else if (ready2 == 0) ready2 = c;
      end
      if (c == 10) begin
        check("held.gap_busy", 32'(bus.busy), 32'd0);
        check("held.gap_mem_req", 32'(bus.mem_req), 32'd0);
      end
      if (c == 11) begin
        check("held.second_req", 32'(bus.mem_req), 32'd1);
        check("held.second_addr", 32'(bus.mem_addr), 32'hABCC);
        bus.miss_req = 1'b0;
      end
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = DW'($urandom);
      step();
    end
    bus.mem_ack  = 1'b0;
    bus.miss_req = 1'b0;
    check("held.first_ready", 32'(ready1), 32'd9);
    check("held.second_ready", 32'(ready2), 32'd19);
    check("held.writes", 32'(nw), 32'd8);
    check("held.end_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/block_fill_engine.md
Name: block_fill_engine

Overview:
- Memory-side refill controller for the cache. On a miss reported by the tag/control table, it fetches one whole block from external memory word by word over a req/ack handshake.
- Each fetched word is written into the block store. When the last word lands, it pulses block_ready so the control table commits the tag and advances its replacement pointer.
- Sits between the control table/block store and the external memory port.

Parameters:
- EXTERNAL_ADDR_SIZE, 16, width of external word address.
- WORD_SIZE, 8, width of one data word.
- WORDS_PER_BLOCK, 4, words per cache block; power of two, at least 2. OFF_BITS = log2(WORDS_PER_BLOCK), localparam.
- TIMEOUT, 15, maximum FETCH cycles without mem_ack before abort; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. 0 resets immediately, independent of clk.
- miss_req  in  1  refill request; sampled only in IDLE.
- miss_addr  in  EXTERNAL_ADDR_SIZE  address that missed.
- flush  in  1  synchronous abort of the current refill.
- mem_req  out  1  external memory read request.
- mem_addr  out  EXTERNAL_ADDR_SIZE  word address being read.
- mem_ack  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  WORD_SIZE  read data.
- fill_we  out  1  write strobe to the block store.
- fill_idx  out  OFF_BITS  word index within the block for fill_data.
- fill_data  out  WORD_SIZE  word to write.
- block_ready  out  1  one-cycle pulse: block completely filled.
- busy  out  1  refill in progress; high in every state except IDLE.
- fill_error  out  1  one-cycle pulse: refill aborted by timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; base, idx and timeout counter cleared.
  - All outputs 0, including mem_addr, fill_idx and fill_data.
  - A reset asserted mid-refill drops mem_req in the same instant and produces no block_ready.
- States: IDLE, FETCH, WRITE, DONE. All outputs are registered; none depends combinationally on inputs.
- IDLE:
  - When miss_req=1: latch base = miss_addr with its low OFF_BITS cleared, set idx=0, go to FETCH.
  - miss_req is ignored in every other state.
- FETCH:
  - mem_req=1 and mem_addr={base[EXTERNAL_ADDR_SIZE-1:OFF_BITS], idx}.
  - Timeout counter increments each FETCH cycle and clears on entry to FETCH.
  - If mem_ack=1: capture mem_rdata into fill_data, drive fill_idx=idx, go to WRITE. An ack in the first FETCH cycle is legal.
  - If mem_ack=0 and the counter reaches TIMEOUT: pulse fill_error for one cycle, drop mem_req, go to IDLE. No block_ready.
- WRITE:
  - fill_we=1 for exactly one cycle; mem_req=0.
  - If idx == WORDS_PER_BLOCK-1: go to DONE. Otherwise idx+1 (wraps within OFF_BITS), back to FETCH.
- DONE: block_ready=1 for one cycle, busy still 1; next state is IDLE.
- Latency with zero-wait memory: miss_req accepted at edge 0 gives block_ready high 2*WORDS_PER_BLOCK+1 cycles later (9 cycles for the defaults). Each memory wait cycle adds one cycle.
- Back-to-back refills: a miss_req seen in the first IDLE cycle after DONE starts a new refill; the minimum gap between refills is that one IDLE cycle.
- flush=1 in any non-IDLE state: go to IDLE on the next edge. mem_req, fill_we and block_ready are 0 in that next cycle.
- Simultaneous events:
  - flush has priority over mem_ack; data acked in the flush cycle is discarded.
  - mem_ack has priority over timeout in the same cycle.
  - flush with miss_req in IDLE: miss_req wins, because flush is a no-op in IDLE.
- mem_ack outside FETCH is ignored.
- fill_data and fill_idx hold their last value outside WRITE.

Test Plan:
- Reset, then miss_req=1 with miss_addr=16'h1237 and zero-wait memory returning AA,BB,CC,DD.
  - mem_addr sequence 1234, 1235, 1236, 1237.
  - fill_we pulses with idx 0..3 and data AA..DD.
  - block_ready high exactly at cycle 9 after acceptance; busy low the cycle after.
- Same request with mem_ack delayed 3 cycles per word → block_ready at cycle 21; mem_addr stable while waiting.
- mem_ack never asserted, TIMEOUT=15 → fill_error pulses once after 15 FETCH cycles; no fill_we, no block_ready; state returns to IDLE.
- flush asserted in the cycle idx=2 is acked → no third fill_we and no block_ready; a new miss_req two cycles later refills normally from idx 0.
- rst driven low asynchronously, between clock edges, during FETCH → mem_req and busy fall before the next edge; all outputs 0.
- miss_req held high through a refill → a second refill starts one IDLE cycle after block_ready, using miss_addr as sampled in that IDLE cycle.
